// File: rtl/run_sequencer.sv
// Run controller for the 9-bit LFSR processor: Req/Ack handshake, FETCH/EXEC/LDWAIT sequencing,
// single-commit gating of decoder strobes, and a saturating cycle watchdog.
module run_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             DecRegWr,
  input  logic             DecStore,
  input  logic             DecLoad,
  input  logic             DecBranch,
  input  logic             BranchTaken,
  input  logic             DecHalt,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadVal,
  output logic             PcInc,
  output logic             PcJump,
  output logic             RegWrEn,
  output logic             MemWrEn,
  output logic             MemRdEn,
  output logic             Busy,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstCnt
);

  localparam logic [CNT_W-1:0] MaxCyc   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [1:0]       WaitLast = 2'(LOAD_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StFetch,
    StExec,
    StLdWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             timeout_q, timeout_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic running;
  logic wd_hit;
  logic jump;

  assign running = (state_q == StFetch) || (state_q == StExec) || (state_q == StLdWait);
  // The counter is checked at the start of the cycle, before this cycle's increment.
  assign wd_hit  = running && (cyc_q == MaxCyc);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cyc_d     = cyc_q;
    inst_d    = inst_q;
    timeout_d = timeout_q;
    PcLoad    = 1'b0;
    PcLoadVal = '0;
    PcInc     = 1'b0;
    PcJump    = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    jump      = 1'b0;

    if (running && !wd_hit) begin
      cyc_d = cyc_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        if (Req) begin
          state_d = StInit;
        end
      end

      StInit: begin
        PcLoad    = 1'b1;
        PcLoadVal = StartAddr;
        cyc_d     = '0;
        inst_d    = '0;
        timeout_d = 1'b0;
        state_d   = StFetch;
      end

      StFetch: begin
        state_d = StExec;
      end

      StExec: begin
        if (DecHalt) begin
          state_d = StDone;
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (DecLoad) begin
          MemRdEn = 1'b1;
          wait_d  = '0;
          state_d = StLdWait;
        end else begin
          jump    = DecBranch & BranchTaken;
          RegWrEn = DecRegWr;
          MemWrEn = DecStore;
          PcJump  = jump;
          PcInc   = ~jump;
          inst_d  = inst_q + CntOne;
          state_d = StFetch;
        end
      end

      StLdWait: begin
        if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          MemRdEn = 1'b1;
          if (wait_q == WaitLast) begin
            RegWrEn = 1'b1;
            PcInc   = 1'b1;
            inst_d  = inst_q + CntOne;
            state_d = StFetch;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
      end

      StDone: begin
        if (!Req) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    ack_d  = (state_d == StDone);
    busy_d = (state_d == StInit) || (state_d == StFetch) ||
             (state_d == StExec) || (state_d == StLdWait);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cyc_q     <= '0;
      inst_q    <= '0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign Ack      = ack_q;
  assign Busy     = busy_q;
  assign Timeout  = timeout_q;
  assign CycleCnt = cyc_q;
  assign InstCnt  = inst_q;

endmodule
